mux_arb_pipe: RTL and testbench
===============================

Name: mux_arb_pipe

Overview:
- Parametrised successor to the combinational 32-bit 4:1 data multiplexer: N input channels, configurable width, one registered output stage with valid/ready handshake.
- Two selection modes: directed (external select, as in pipeline forwarding/writeback selection) or round-robin arbitration (shared-resource ports, e.g. memory request merging).
- Sits between pipeline stages where the selected operand must be registered and back-pressure honoured.

Parameters:
- WIDTH, 32, data width per channel
- NUM_IN, 4, number of input channels (2..16)
- SEL_W, $clog2(NUM_IN), width of select_i / src_o
- MODE, 0, 0 = directed by select_i, 1 = round-robin

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous flush of output stage
- valid_i  in  NUM_IN  per-channel request valid
- data_i  in  NUM_IN*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- ready_o  out  NUM_IN  per-channel accept (one-hot or zero)
- select_i  in  SEL_W  channel select, used only when MODE=0
- valid_o  out  1  output register holds data
- data_o  out  WIDTH  registered selected data
- src_o  out  SEL_W  index of channel that produced data_o
- ready_i  in  1  downstream accept

Behaviour:
- Reset (rst_i=0, asynchronous): valid_o=0, data_o=0, src_o=0, RR pointer=0. No handshake completes while reset is asserted; a transfer in flight is dropped.
- Output slot free: slot_free = ~valid_o | ready_i.
- Grant, MODE=0: grant[k]=1 iff k==select_i and valid_i[k]. select_i >= NUM_IN grants nothing.
- Grant, MODE=1: the first k with valid_i[k], searching from ptr upward with wrap mod NUM_IN. No valid_i means no grant.
- ready_o[k] = grant[k] & slot_free & ~flush_i. This is combinational and may depend on valid_i. valid_i must not depend on ready_o.
- Accept: a channel k with valid_i[k]&ready_o[k] is accepted on that clock edge. Next cycle: valid_o=1, data_o=data_i[k], src_o=k. Latency is 1 cycle.
- Full throughput: one accept per cycle when ready_i is held at 1.
- Output consumed (valid_o&ready_i) with no new accept: valid_o->0. data_o and src_o hold their last values.
- Stall (valid_o&~ready_i): data_o and src_o stay stable, ready_o is all 0. The upstream channel must hold valid_i and data until accepted.
- RR pointer updates only on an accept: ptr <= (k+1) mod NUM_IN. It is unchanged in cycles with no accept or with flush.
- flush_i=1: valid_o->0 next cycle, no accept that cycle. Takes priority over both accept and consume.
- Simultaneous consume and accept: valid_o stays 1 and the output register loads the new data (bypass of the free slot).
- In MODE=0, select_i changes are legal at any cycle. Only the value at the accepting edge matters.

Decomposition:
- Package mux_arb_pkg: localparams MODE_DIRECTED=0 and MODE_RR=1, plus a function for one-hot-to-index.
- Sub-module rr_arbiter (NUM_IN): holds ptr and produces a one-hot grant from a request vector. Its advance input is driven by the accept.
- The top level holds the output register, the directed-select path and the handshake logic.

Test Plan:
- Reset mid-stream: MODE=0, ch2 data 0xDEADBEEF accepted, assert rst_i=0 before ready_i -> valid_o=0, data_o=0, src_o=0 immediately; no accept after release until valid_i is seen again.
- Directed select: MODE=0, valid_i=4'b1111, data ch0..3=0x10/0x11/0x12/0x13, select_i=2, ready_i=1 -> ready_o=4'b0100; next cycle data_o=0x12, src_o=2, valid_o=1.
- Backpressure: ready_i=0 for 3 cycles after a load of 0xA5 -> data_o stays 0xA5, ready_o=0 throughout; ready_i=1 with valid_i[1], data 0x5A -> consume and load same cycle, data_o=0x5A next cycle, valid_o stays 1.
- Round-robin fairness: MODE=1, all four valid, ready_i=1 for 8 cycles -> src_o sequence 0,1,2,3,0,1,2,3; with only ch1 and ch3 valid -> 1,3,1,3.
- Flush priority: valid_o=1, ready_i=1, valid_i[0]=1, flush_i=1 -> ready_o=0, valid_o=0 next cycle, RR ptr unchanged.
- Boundaries: NUM_IN=2, WIDTH=8, MODE=0, select_i=1 with valid_i=2'b01 -> no grant, valid_o stays 0; MODE=1 wrap from ptr=1 with only ch0 valid -> src_o=0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared selection-mode constants and index helpers for the registered channel mux.
package mux_arb_pkg;

  localparam int MODE_DIRECTED = 0;
  localparam int MODE_RR       = 1;

  // Index of the set bit in a one-hot vector; zero when no bit is set.
  function automatic int unsigned onehot_to_idx(input logic [15:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_arb_pipe_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr,
// pointer moves past the granted channel only when the grant is consumed.
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_IN-1:0] req_i,
  input  logic              advance_i,
  output logic [NUM_IN-1:0] grant_o
);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               gidx;
  int               nxt;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    gidx    = 0;
    for (int off = 0; off < NUM_IN; off++) begin
      gidx = (int'(ptr_q) + off) % NUM_IN;
      if (!found && req_i[gidx]) begin
        grant_o[gidx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    nxt   = int'(onehot_to_idx(16'(grant_o))) + 1;
    if (advance_i) begin
      ptr_d = (nxt == NUM_IN) ? '0 : SEL_W'(nxt);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mux_arb_pipe.sv
// N-channel mux with a single registered output slot and valid/ready handshake;
// channel chosen by external select or by round-robin arbitration.
module mux_arb_pipe
  import mux_arb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN),
  parameter int MODE   = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic [NUM_IN-1:0]       valid_i,
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  output logic [NUM_IN-1:0]       ready_o,
  input  logic [SEL_W-1:0]        select_i,
  output logic                    valid_o,
  output logic [WIDTH-1:0]        data_o,
  output logic [SEL_W-1:0]        src_o,
  input  logic                    ready_i
);

  logic [NUM_IN-1:0] grant;
  logic [NUM_IN-1:0] acc_vec;
  logic              slot_free;
  logic              accept;
  int unsigned       acc_idx;

  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SEL_W-1:0]  src_q, src_d;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic unused_select;
      assign unused_select = ^select_i;
      rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
      ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (valid_i),
        .advance_i (accept),
        .grant_o   (grant)
      );
    end else begin : g_dir
      for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ch
        assign grant[gi] = valid_i[gi] & (select_i == SEL_W'(gi));
      end
    end
  endgenerate

  // Gating with rst_i keeps any handshake from completing while reset is held.
  assign slot_free = ~valid_q | ready_i;
  assign ready_o   = grant & {NUM_IN{slot_free & ~flush_i & rst_i}};
  assign acc_vec   = valid_i & ready_o;
  assign accept    = |acc_vec;

  always_comb begin
    acc_idx = onehot_to_idx(16'(acc_vec));
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      data_d  = data_i[acc_idx*WIDTH +: WIDTH];
      src_d   = SEL_W'(acc_idx);
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign src_o   = src_q;

endmodule

// File: tb/tb_mux_arb_pipe.sv
// Drives four configurations of mux_arb_pipe from shared stimulus and checks
// each against a per-channel behavioural model every cycle, plus directed literals.
module tb_mux_arb_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        rdy_in = 1'b0;
  logic [3:0]  sel = '0;
  logic [3:0]  vin = '0;
  logic [31:0] dch [4];
  logic        started = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  logic [127:0] d4;
  logic [15:0]  d2;
  assign d4 = {dch[3], dch[2], dch[1], dch[0]};
  assign d2 = {dch[1][7:0], dch[0][7:0]};

  logic [3:0]  rdy0, rdy1;
  logic [1:0]  rdy2, rdy3;
  logic        val0, val1, val2, val3;
  logic [31:0] dat0, dat1;
  logic [7:0]  dat2, dat3;
  logic [1:0]  src0, src1;
  logic [0:0]  src2, src3;

  mux_arb_pipe #(.WIDTH(32), .NUM_IN(4), .MODE(0)) u0 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .valid_i(vin), .data_i(d4),
    .ready_o(rdy0), .select_i(sel[1:0]), .valid_o(val0), .data_o(dat0),
    .src_o(src0), .ready_i(rdy_in));
  mux_arb_pipe #(.WIDTH(32), .NUM_IN(4), .MODE(1)) u1 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .valid_i(vin), .data_i(d4),
    .ready_o(rdy1), .select_i(sel[1:0]), .valid_o(val1), .data_o(dat1),
    .src_o(src1), .ready_i(rdy_in));
  mux_arb_pipe #(.WIDTH(8), .NUM_IN(2), .MODE(0)) u2 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .valid_i(vin[1:0]), .data_i(d2),
    .ready_o(rdy2), .select_i(sel[0:0]), .valid_o(val2), .data_o(dat2),
    .src_o(src2), .ready_i(rdy_in));
  mux_arb_pipe #(.WIDTH(8), .NUM_IN(2), .MODE(1)) u3 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .valid_i(vin[1:0]), .data_i(d2),
    .ready_o(rdy3), .select_i(sel[0:0]), .valid_o(val3), .data_o(dat3),
    .src_o(src3), .ready_i(rdy_in));

  logic [31:0] a_dat [4];
  logic [3:0]  a_rdy [4];
  logic        a_val [4];
  int          a_src [4];

  always_comb begin
    a_val[0] = val0; a_val[1] = val1; a_val[2] = val2; a_val[3] = val3;
    a_dat[0] = dat0; a_dat[1] = dat1; a_dat[2] = {24'h0, dat2}; a_dat[3] = {24'h0, dat3};
    a_rdy[0] = rdy0; a_rdy[1] = rdy1; a_rdy[2] = {2'b00, rdy2}; a_rdy[3] = {2'b00, rdy3};
    a_src[0] = int'(src0); a_src[1] = int'(src1); a_src[2] = int'(src2); a_src[3] = int'(src3);
  end

  // Model: per configuration, what the output slot holds and where RR search starts.
  int          cfg_n    [4] = '{4, 4, 2, 2};
  int          cfg_mode [4] = '{0, 1, 0, 1};
  logic [31:0] cfg_mask [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_00FF};
  logic        m_val [4];
  logic [31:0] m_dat [4];
  int          m_src [4];
  int          m_ptr [4];

  function automatic int mgrant(input int c);
    int n;
    int s;
    n = cfg_n[c];
    if (cfg_mode[c] == 0) begin
      s = int'(sel) % n;
      return vin[s] ? s : -1;
    end
    for (int off = 0; off < n; off++) begin
      s = (m_ptr[c] + off) % n;
      if (vin[s]) return s;
    end
    return -1;
  endfunction

  function automatic logic [3:0] mready(input int c);
    int g;
    logic [3:0] r;
    g = mgrant(c);
    r = '0;
    if (g >= 0 && rst_n && !flush && (!m_val[c] || rdy_in)) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) begin
        m_val[c] <= 1'b0;
        m_dat[c] <= '0;
        m_src[c] <= 0;
        m_ptr[c] <= 0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (flush) begin
          m_val[c] <= 1'b0;
        end else if (mready(c) != 4'b0000) begin
          m_val[c] <= 1'b1;
          m_dat[c] <= dch[mgrant(c)] & cfg_mask[c];
          m_src[c] <= mgrant(c);
          if (cfg_mode[c] == 1) m_ptr[c] <= (mgrant(c) + 1) % cfg_n[c];
        end else if (m_val[c] && rdy_in) begin
          m_val[c] <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s u%0d: got %0h want %0h at %0t", nm, c, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int c = 0; c < 4; c++) begin
        check("valid_o", c, 32'(a_val[c]), 32'(m_val[c]));
        check("data_o", c, a_dat[c], m_dat[c]);
        check("src_o", c, a_src[c], m_src[c]);
        check("ready_o", c, 32'(a_rdy[c]), 32'(mready(c)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) dch[i] = '0;
    repeat (2) @(posedge clk);
    started = 1'b1;
    #1;
    check("lit_reset_valid", 0, 32'(val0), 32'd0);
    check("lit_reset_data", 0, dat0, 32'd0);
    check("lit_reset_src", 0, 32'(src0), 32'd0);
    rst_n = 1'b1;

    // Directed select of channel 2
    vin = 4'b1111; sel = 4'd2; rdy_in = 1'b1;
    dch[0] = 32'h10; dch[1] = 32'h11; dch[2] = 32'h12; dch[3] = 32'h13;
    #1;
    check("lit_dir_ready", 0, 32'(rdy0), 32'h4);
    tick();
    check("lit_dir_data", 0, dat0, 32'h12);
    check("lit_dir_src", 0, 32'(src0), 32'd2);
    check("lit_dir_valid", 0, 32'(val0), 32'd1);

    // Backpressure then consume-and-load in the same cycle
    vin = 4'b0001; dch[0] = 32'hA5; sel = 4'd0;
    tick();
    check("lit_bp_load", 0, dat0, 32'hA5);
    vin = 4'b0010; dch[1] = 32'h5A; sel = 4'd1; rdy_in = 1'b0;
    repeat (3) begin
      #1;
      check("lit_bp_ready", 0, 32'(rdy0), 32'd0);
      tick();
      check("lit_bp_hold", 0, dat0, 32'hA5);
      check("lit_bp_valid", 0, 32'(val0), 32'd1);
    end
    rdy_in = 1'b1;
    #1;
    check("lit_bypass_ready", 0, 32'(rdy0), 32'h2);
    tick();
    check("lit_bypass_data", 0, dat0, 32'h5A);
    check("lit_bypass_valid", 0, 32'(val0), 32'd1);
    vin = 4'b0000;
    tick();
    check("lit_drain_valid", 0, 32'(val0), 32'd0);
    check("lit_drain_hold", 0, dat0, 32'h5A);

    // Reset while a transfer sits in the output slot
    vin = 4'b0100; dch[2] = 32'hDEAD_BEEF; sel = 4'd2; rdy_in = 1'b0;
    tick();
    check("lit_pre_rst_data", 0, dat0, 32'hDEAD_BEEF);
    vin = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    check("lit_rst_valid", 0, 32'(val0), 32'd0);
    check("lit_rst_data", 0, dat0, 32'd0);
    check("lit_rst_src", 0, 32'(src0), 32'd0);
    tick();
    tick();
    rst_n = 1'b1; rdy_in = 1'b1;
    tick();
    check("lit_post_rst_valid", 0, 32'(val0), 32'd0);

    // Round-robin fairness
    vin = 4'b1111;
    for (int i = 0; i < 4; i++) dch[i] = 32'h20 + 32'(i);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("lit_rr_all", 1, 32'(src1), 32'(i % 4));
      check("lit_rr_valid", 1, 32'(val1), 32'd1);
    end
    vin = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("lit_rr_odd", 1, 32'(src1), (i % 2 == 1) ? 32'd3 : 32'd1);
    end

    // Flush beats both consume and accept; RR pointer must not move
    vin = 4'b0001; sel = 4'd0; flush = 1'b1;
    #1;
    check("lit_flush_ready", 1, 32'(rdy1), 32'd0);
    check("lit_flush_ready", 0, 32'(rdy0), 32'd0);
    tick();
    check("lit_flush_valid", 1, 32'(val1), 32'd0);
    check("lit_flush_valid", 0, 32'(val0), 32'd0);
    flush = 1'b0; vin = 4'b1111;
    tick();
    check("lit_flush_ptr", 1, 32'(src1), 32'd0);
    check("lit_flush_ptr_valid", 1, 32'(val1), 32'd1);

    // Two-channel boundaries
    vin = 4'b0000;
    tick();
    sel = 4'd1; vin = 4'b0001;
    #1;
    check("lit_n2_nogrant", 2, 32'(rdy2), 32'd0);
    tick();
    check("lit_n2_idle", 2, 32'(val2), 32'd0);
    tick();
    check("lit_n2_wrap_src", 3, 32'(src3), 32'd0);
    check("lit_n2_wrap_valid", 3, 32'(val3), 32'd1);
    vin = 4'b0000;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
